uart_cmd_ctrl: RTL and testbench

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

---
 rtl/uart_cmd_ctrl_if.sv | 39 +++
 rtl/uart_cmd_ctrl.sv | 177 +++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_ctrl_if.sv
// rtl/uart_cmd_ctrl_if.sv - command, register-bus and response signal bundle for uart_cmd_ctrl
interface uart_cmd_ctrl_if;
    logic        cmd_valid;
    logic        cmd_r;
    logic        cmd_w;
    logic        cmd_fail;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_full;
    logic        overflow;

    logic        bus_req;
    logic        bus_we;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_data;

    // Controller view
    modport slave (
        input  cmd_valid, cmd_r, cmd_w, cmd_fail, cmd_addr, cmd_data,
        input  bus_ack, bus_rdata, rsp_ready,
        output cmd_full, overflow, bus_req, bus_we, bus_addr, bus_wdata,
        output rsp_valid, rsp_status, rsp_data
    );

    // Decoder / register bus / transmitter view
    modport master (
        output cmd_valid, cmd_r, cmd_w, cmd_fail, cmd_addr, cmd_data,
        output bus_ack, bus_rdata, rsp_ready,
        input  cmd_full, overflow, bus_req, bus_we, bus_addr, bus_wdata,
        input  rsp_valid, rsp_status, rsp_data
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - command queue + IDLE/ISSUE/RESP bus sequencer; UART_CTRL_TIMEOUT_EN adds an ack timeout
module uart_cmd_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    uart_cmd_ctrl_if.slave  io
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = 43;

    // Reject configurations the pointer arithmetic and 8-bit timeout counter cannot support
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_cfg
        $error("uart_cmd_ctrl: FIFO_DEPTH or TIMEOUT_CYC out of range");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic             bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [7:0]       bus_addr_q, bus_addr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_status_q, rsp_status_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
`ifdef UART_CTRL_TIMEOUT_EN
    logic [7:0]       tmo_q, tmo_d;
`endif

    logic             full, push, pop;
    logic [ENT_W-1:0] head;

    assign full = (count_q == CNT_W'(FIFO_DEPTH));
    // A full queue drops the command even if the FSM pops this same cycle
    assign push = io.cmd_valid && !full;
    assign head = mem_q[rd_ptr_q];

    assign io.cmd_full   = full;
    assign io.overflow   = io.cmd_valid && full;
    assign io.bus_req    = bus_req_q;
    assign io.bus_we     = bus_we_q;
    assign io.bus_addr   = bus_addr_q;
    assign io.bus_wdata  = bus_wdata_q;
    assign io.rsp_valid  = rsp_valid_q;
    assign io.rsp_status = rsp_status_q;
    assign io.rsp_data   = rsp_data_q;

    // Queue storage, pointers (wrap by power-of-two overflow) and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = {io.cmd_r, io.cmd_w, io.cmd_fail, io.cmd_addr, io.cmd_data};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    end

    // Sequencer: pop a command, run the bus access, then hold the response until taken
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_status_d = rsp_status_q;
        rsp_data_d   = rsp_data_q;
`ifdef UART_CTRL_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    // Exactly one of R/W with no decode failure is a legal bus command
                    if (!head[40] && (head[42] ^ head[41])) begin
                        state_d     = ISSUE;
                        bus_req_d   = 1'b1;
                        bus_we_d    = head[41];
                        bus_addr_d  = head[39:32];
                        bus_wdata_d = head[31:0];
`ifdef UART_CTRL_TIMEOUT_EN
                        tmo_d       = 8'd0;
`endif
                    end else begin
                        state_d      = RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = 2'b10;
                        rsp_data_d   = 32'd0;
                    end
                end
            end
            ISSUE: begin
`ifdef UART_CTRL_TIMEOUT_EN
                tmo_d = tmo_q + 8'd1;
`endif
                // Ack wins over a timeout landing on the same cycle
                if (io.bus_ack) begin
                    state_d      = RESP;
                    bus_req_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = bus_we_q ? 2'b00 : 2'b01;
                    rsp_data_d   = bus_we_q ? 32'd0 : io.bus_rdata;
                end
`ifdef UART_CTRL_TIMEOUT_EN
                else if (tmo_d == 8'(TIMEOUT_CYC)) begin
                    state_d      = RESP;
                    bus_req_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = 2'b11;
                    rsp_data_d   = 32'd0;
                    tmo_d        = 8'd0;
                end
`endif
            end
            RESP: begin
                if (io.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any transaction and empties the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 8'd0;
            bus_wdata_q  <= 32'd0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= 2'b00;
            rsp_data_q   <= 32'd0;
`ifdef UART_CTRL_TIMEOUT_EN
            tmo_q        <= 8'd0;
`endif
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_data_q   <= rsp_data_d;
`ifdef UART_CTRL_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - scoreboard bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_cmd_ctrl_if io();

    uart_cmd_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    int checks = 0;
    int errors = 0;

    logic [33:0] sb [$];
    logic [33:0] mon_exp;
    int  rsp_count    = 0;
    int  ack_lat      = 1;
    bit  ack_en       = 1'b1;
    int  req_run      = 0;
    int  last_req_len = 0;
    int  req_rises    = 0;
    bit  tmo_expect   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [7:0] a);
        return {16'h0000, 8'hA5, a ^ 8'hA0};
    endfunction

    // Register-bus model: acks after ack_lat request cycles, read data derived from address
    initial begin
        io.bus_ack   = 1'b0;
        io.bus_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_run    = 0;
                io.bus_ack = 1'b0;
            end else if (io.bus_req) begin
                if (req_run == 0) req_rises++;
                req_run++;
                io.bus_ack   = ack_en && (req_run >= ack_lat);
                io.bus_rdata = io.bus_ack ? rd_fn(io.bus_addr) : $urandom;
            end else begin
                if (req_run != 0) last_req_len = req_run;
                req_run    = 0;
                io.bus_ack = 1'b0;
            end
        end
    end

    // Response monitor: every accepted response is compared with the head of the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && io.rsp_valid && io.rsp_ready) begin
                rsp_count++;
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    mon_exp = sb.pop_front();
                    check("rsp_status", io.rsp_status, mon_exp[33:32]);
                    check("rsp_data", io.rsp_data, mon_exp[31:0]);
                end
            end
        end
    end

    task automatic send(input bit r, input bit w, input bit f, input logic [7:0] a,
                        input logic [31:0] d, input bit exp_drop, input string tag);
        logic [33:0] e;
        @(posedge clk); #1;
        io.cmd_valid = 1'b1;
        io.cmd_r     = r;
        io.cmd_w     = w;
        io.cmd_fail  = f;
        io.cmd_addr  = a;
        io.cmd_data  = d;
        @(negedge clk);
        check({tag, "_overflow"}, io.overflow, exp_drop);
        if (!exp_drop) begin
            if (f || (r == w))   e = {2'b10, 32'd0};
            else if (tmo_expect) e = {2'b11, 32'd0};
            else if (w)          e = {2'b00, 32'd0};
            else                 e = {2'b01, rd_fn(a)};
            sb.push_back(e);
        end
        @(posedge clk); #1;
        io.cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_drain"}, sb.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0;
        int c0;
        int n;
        rst          = 1'b1;
        io.cmd_valid = 1'b0;
        io.cmd_r     = 1'b0;
        io.cmd_w     = 1'b0;
        io.cmd_fail  = 1'b0;
        io.cmd_addr  = 8'd0;
        io.cmd_data  = 32'd0;
        io.rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bus_req", io.bus_req, 0);
        check("rst_rsp_valid", io.rsp_valid, 0);
        check("rst_cmd_full", io.cmd_full, 0);
        check("rst_overflow", io.overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Write: request held for 3 cycles, 1-cycle latency from the IDLE pop
        ack_lat = 3;
        send(1'b0, 1'b1, 1'b0, 8'h12, 32'hDEADBEEF, 1'b0, "wr");
        @(negedge clk);
        check("wr_lat_pre", io.bus_req, 0);
        @(negedge clk);
        check("wr_req", io.bus_req, 1);
        check("wr_we", io.bus_we, 1);
        check("wr_addr", io.bus_addr, 8'h12);
        check("wr_wdata", io.bus_wdata, 32'hDEADBEEF);
        drain(50, "wr");
        check("wr_req_len", last_req_len, 3);

        // Read: response held stable while ready is low
        ack_lat = 1;
        io.rsp_ready = 1'b0;
        send(1'b1, 1'b0, 1'b0, 8'h05, 32'd0, 1'b0, "rd");
        n = 0;
        while (!io.rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("rd_valid", io.rsp_valid, 1);
        check("rd_status", io.rsp_status, 2'b01);
        check("rd_data", io.rsp_data, 32'h0000A5A5);
        repeat (3) @(negedge clk);
        check("rd_hold_valid", io.rsp_valid, 1);
        check("rd_hold_data", io.rsp_data, 32'h0000A5A5);
        @(posedge clk); #1;
        io.rsp_ready = 1'b1;
        drain(20, "rd");

        // Invalid commands never touch the bus
        r0 = req_rises;
        send(1'b0, 1'b1, 1'b1, 8'h20, 32'd1, 1'b0, "inv_fail");
        send(1'b1, 1'b1, 1'b0, 8'h21, 32'd2, 1'b0, "inv_rw");
        send(1'b0, 1'b0, 1'b0, 8'h22, 32'd3, 1'b0, "inv_none");
        drain(50, "inv");
        check("inv_no_req", req_rises - r0, 0);

        // Overflow: first command stalls in ISSUE, four fill the queue, the rest drop
        ack_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send(1'b1, 1'b0, 1'b0, 8'h40 + 8'(i), 32'd0, (i >= 5), $sformatf("ovf%0d", i));
            @(negedge clk);
            check($sformatf("ovf%0d_full", i), io.cmd_full, (i >= 4));
        end
        ack_en  = 1'b1;
        ack_lat = 2;
        drain(300, "ovf");
        check("ovf_empty_full", io.cmd_full, 0);

`ifdef UART_CTRL_TIMEOUT_EN
        // Timeout after TMO request cycles, and an ack on the boundary cycle still wins
        ack_en     = 1'b0;
        tmo_expect = 1'b1;
        send(1'b1, 1'b0, 1'b0, 8'h33, 32'd0, 1'b0, "tmo");
        tmo_expect = 1'b0;
        drain(60, "tmo");
        check("tmo_req_len", last_req_len, TMO);
        ack_en  = 1'b1;
        ack_lat = TMO;
        send(1'b1, 1'b0, 1'b0, 8'h34, 32'd0, 1'b0, "tmo_edge");
        drain(60, "tmo_edge");
        check("tmo_edge_req_len", last_req_len, TMO);
`else
        // No timeout: the request is held indefinitely
        ack_en = 1'b0;
        send(1'b1, 1'b0, 1'b0, 8'h33, 32'd0, 1'b0, "hold");
        repeat (1000) @(posedge clk);
        @(negedge clk);
        check("hold_req", io.bus_req, 1);
        check("hold_no_rsp", io.rsp_valid, 0);
        ack_en  = 1'b1;
        ack_lat = 1;
        drain(20, "hold");
`endif

        // Reset during ISSUE with a full queue aborts everything
        ack_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'b0, 1'b0, 8'h60 + 8'(i), 32'd0, 1'b0, $sformatf("rst%0d", i));
        end
        @(negedge clk);
        check("pre_rst_req", io.bus_req, 1);
        check("pre_rst_full", io.cmd_full, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_bus_req", io.bus_req, 0);
        check("arst_cmd_full", io.cmd_full, 0);
        check("arst_bus_addr", io.bus_addr, 0);
        check("arst_rsp_valid", io.rsp_valid, 0);
        check("arst_rsp_status", io.rsp_status, 0);
        sb.delete();
        c0 = rsp_count;
        r0 = req_rises;
        ack_en  = 1'b1;
        ack_lat = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        check("post_rst_no_rsp", rsp_count - c0, 0);
        check("post_rst_no_req", req_rises - r0, 0);
        send(1'b0, 1'b1, 1'b0, 8'h7E, 32'h12345678, 1'b0, "post_rst");
        drain(30, "post_rst");
        check("post_rst_one_rsp", rsp_count - c0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
